// File: rtl/dl2_mem_bridge.sv
// Main-memory backing stage below the L2 data cache (B side): sub-block burst
// writebacks in, fixed-latency sub-block burst fills out, one transaction at a time.
module dl2_mem_bridge #(
  parameter int ADDR_BITS        = 32,
  parameter int SUB_W            = 128,
  parameter int SUBBLOCKS        = 4,
  parameter int SUBBLOCKS_LOG2   = 2,
  parameter int BLOCK_BYTES_LOG2 = 6,
  parameter int MEM_BLOCKS_LOG2  = 10,
  parameter int READ_LATENCY     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_BITS-1:0]      addrB,
  input  logic                      enB,
  input  logic                      weB,
  input  logic [SUBBLOCKS_LOG2-1:0] doutBstrobe,
  input  logic [SUB_W-1:0]          doutB,
  output logic [SUBBLOCKS_LOG2-1:0] dinBstrobe,
  output logic [SUB_W-1:0]          dinB,
  output logic                      dreadyB,
  output logic                      accR,
  output logic                      accW,
  input  logic                      flush_in,
  output logic                      flush_done,
  output logic                      proto_err,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  localparam int MEM_DEPTH = 1 << (MEM_BLOCKS_LOG2 + SUBBLOCKS_LOG2);
  localparam int LAT_W     = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [SUBBLOCKS_LOG2-1:0] LAST_BEAT = SUBBLOCKS_LOG2'(SUBBLOCKS - 1);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_BURST} state_t;

  state_t                      state, state_next;
  logic [MEM_BLOCKS_LOG2-1:0]  blk;
  logic [MEM_BLOCKS_LOG2-1:0]  addr_blk;
  logic [SUBBLOCKS_LOG2-1:0]   wr_idx;
  logic [LAT_W-1:0]            lat_cnt;
  logic                        flush_pend;
  logic [SUB_W-1:0]            mem [MEM_DEPTH];

  logic                        mem_we;
  logic                        latch_addr;
  logic                        load_lat;
  logic                        wr_advance;
  logic                        wr_done;
  logic                        emit;
  logic [SUBBLOCKS_LOG2-1:0]   emit_idx;
  logic                        err_set;
  logic                        flush_req;
  logic                        flush_fire;
  logic [MEM_BLOCKS_LOG2+SUBBLOCKS_LOG2-1:0] mem_widx;
  logic [MEM_BLOCKS_LOG2+SUBBLOCKS_LOG2-1:0] mem_ridx;
  logic                        unused_addr;

  // Address bits above the stored range alias; bits inside the block are don't-care.
  assign addr_blk    = addrB[BLOCK_BYTES_LOG2 +: MEM_BLOCKS_LOG2];
  assign unused_addr = ^{addrB[ADDR_BITS-1:BLOCK_BYTES_LOG2+MEM_BLOCKS_LOG2],
                         addrB[BLOCK_BYTES_LOG2-1:0]};

  assign accR = (state == IDLE);
  assign accW = (state == IDLE);

  // Beat 0 of a writeback commits on the same edge the address is latched.
  assign mem_widx   = {(state == IDLE) ? addr_blk : blk, doutBstrobe};
  assign mem_ridx   = {blk, emit_idx};
  assign flush_req  = flush_pend | flush_in;
  assign flush_fire = flush_req && (state_next == IDLE);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    latch_addr = 1'b0;
    load_lat   = 1'b0;
    wr_advance = 1'b0;
    wr_done    = 1'b0;
    emit       = 1'b0;
    emit_idx   = '0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (weB) begin
          if (enB) err_set = 1'b1;
          if (doutBstrobe == '0) begin
            mem_we     = 1'b1;
            latch_addr = 1'b1;
            state_next = WR;
          end else begin
            err_set = 1'b1;
          end
        end else if (enB) begin
          latch_addr = 1'b1;
          load_lat   = 1'b1;
          state_next = RD_WAIT;
        end
      end
      WR: begin
        if (enB) err_set = 1'b1;
        if (weB) begin
          if (doutBstrobe == wr_idx) begin
            mem_we     = 1'b1;
            wr_advance = 1'b1;
            if (wr_idx == LAST_BEAT) begin
              wr_done    = 1'b1;
              state_next = IDLE;
            end
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (weB || enB) err_set = 1'b1;
        if (lat_cnt == '0) begin
          emit       = 1'b1;
          state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        if (weB || enB) err_set = 1'b1;
        // Stay here while the last beat is on the bus so acceptance drops through it.
        if (dinBstrobe == LAST_BEAT) begin
          state_next = IDLE;
        end else begin
          emit     = 1'b1;
          emit_idx = dinBstrobe + SUBBLOCKS_LOG2'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      blk        <= '0;
      wr_idx     <= '0;
      lat_cnt    <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      proto_err  <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      dreadyB    <= 1'b0;
      dinBstrobe <= '0;
      dinB       <= '0;
    end else begin
      state <= state_next;
      if (latch_addr) blk <= addr_blk;

      if (state == IDLE && mem_we)
        wr_idx <= SUBBLOCKS_LOG2'(1);
      else if (wr_advance)
        wr_idx <= wr_idx + SUBBLOCKS_LOG2'(1);

      // Counter loads LATENCY-2: one edge enters RD_WAIT, one edge registers beat 0.
      if (load_lat)
        lat_cnt <= LAT_W'(READ_LATENCY - 2);
      else if (state == RD_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - LAT_W'(1);

      if (err_set) proto_err <= 1'b1;
      if (wr_done) wr_count <= wr_count + 32'd1;

      dreadyB <= emit;
      if (emit) begin
        dinBstrobe <= emit_idx;
        dinB       <= mem[mem_ridx];
        if (emit_idx == LAST_BEAT) rd_count <= rd_count + 32'd1;
      end

      flush_done <= flush_fire;
      flush_pend <= flush_req && !flush_fire;
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and only writes change them.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_widx] <= doutB;
  end

endmodule

// File: tb/tb_dl2_mem_bridge.sv
// Directed bench for dl2_mem_bridge: bursts, read latency, protocol errors,
// aliasing, flush acknowledge and asynchronous reset.
module tb_dl2_mem_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addrB = '0;
  logic         enB = 1'b0;
  logic         weB = 1'b0;
  logic [1:0]   doutBstrobe = '0;
  logic [127:0] doutB = '0;
  logic [1:0]   dinBstrobe;
  logic [127:0] dinB;
  logic         dreadyB;
  logic         accR;
  logic         accW;
  logic         flush_in = 1'b0;
  logic         flush_done;
  logic         proto_err;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [127:0] rd_data [4];
  logic [1:0]   rd_strb [4];
  int           rd_cyc  [4];
  int           nbeats;
  int           acc_k;

  dl2_mem_bridge dut (
    .clk(clk), .reset(reset), .addrB(addrB), .enB(enB), .weB(weB),
    .doutBstrobe(doutBstrobe), .doutB(doutB), .dinBstrobe(dinBstrobe),
    .dinB(dinB), .dreadyB(dreadyB), .accR(accR), .accW(accW),
    .flush_in(flush_in), .flush_done(flush_done), .proto_err(proto_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1; weB = 1'b0; enB = 1'b0; flush_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_beat(input logic [31:0] a, input logic [1:0] s, input logic [127:0] d);
    addrB = a; weB = 1'b1; doutBstrobe = s; doutB = d;
    @(negedge clk);
    weB = 1'b0;
  endtask

  // Issues enB for one edge T; k counts negedges after T (k=1 is cycle T+1).
  task automatic read_block(input logic [31:0] a);
    nbeats = 0; acc_k = 0;
    for (int i = 0; i < 4; i++) begin rd_cyc[i] = -1; rd_data[i] = '0; rd_strb[i] = '0; end
    addrB = a; enB = 1'b1;
    @(negedge clk);
    enB = 1'b0;
    for (int k = 1; k <= 20 && acc_k == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (dreadyB) begin
        if (nbeats < 4) begin
          rd_data[nbeats] = dinB; rd_strb[nbeats] = dinBstrobe; rd_cyc[nbeats] = k;
        end
        nbeats++;
      end
      if (accR) acc_k = k;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge clk);
    checks++; if (accR !== 1'b1) begin errors++; $display("FAIL reset_accR got %b exp 1", accR); end
    checks++; if (accW !== 1'b1) begin errors++; $display("FAIL reset_accW got %b exp 1", accW); end
    checks++; if (dreadyB !== 1'b0) begin errors++; $display("FAIL reset_dreadyB got %b exp 0", dreadyB); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_rd_count got %0d exp 0", rd_count); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
  endtask

  task automatic test_write_read();
    write_beat(32'h1040, 2'd0, 128'hA0);
    checks++; if (accW !== 1'b0) begin errors++; $display("FAIL wr_burst_accW got %b exp 0", accW); end
    write_beat(32'h1040, 2'd1, 128'hA1);
    write_beat(32'h1040, 2'd2, 128'hA2);
    write_beat(32'h1040, 2'd3, 128'hA3);
    checks++; if (accW !== 1'b1) begin errors++; $display("FAIL wr_end_accW got %b exp 1", accW); end
    read_block(32'h1040);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL wr_rd_nbeats got %0d exp 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_cyc[i] !== 3 + i) begin errors++; $display("FAIL wr_rd_beat%0d_cycle got %0d exp %0d", i, rd_cyc[i], 3 + i); end
      checks++; if (rd_strb[i] !== 2'(i)) begin errors++; $display("FAIL wr_rd_beat%0d_strobe got %0d exp %0d", i, rd_strb[i], i); end
      checks++; if (rd_data[i] !== 128'hA0 + 128'(i)) begin errors++; $display("FAIL wr_rd_beat%0d_data got %h exp %h", i, rd_data[i], 128'hA0 + 128'(i)); end
    end
    checks++; if (acc_k !== 7) begin errors++; $display("FAIL wr_rd_accR_cycle got %0d exp 7", acc_k); end
    checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL wr_rd_wr_count got %0d exp 1", wr_count); end
    checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL wr_rd_rd_count got %0d exp 1", rd_count); end
  endtask

  task automatic test_gap_stray();
    write_beat(32'h2080, 2'd0, 128'hB0);
    write_beat(32'h2080, 2'd1, 128'hB1);
    repeat (2) @(negedge clk);
    checks++; if (accW !== 1'b0) begin errors++; $display("FAIL gap_hold_accW got %b exp 0", accW); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL gap_proto_err got %b exp 0", proto_err); end
    write_beat(32'h2080, 2'd3, 128'hDEAD);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL stray_proto_err got %b exp 1", proto_err); end
    write_beat(32'h2080, 2'd2, 128'hB2);
    write_beat(32'h2080, 2'd3, 128'hB3);
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL gap_wr_count got %0d exp 2", wr_count); end
    checks++; if (accW !== 1'b1) begin errors++; $display("FAIL gap_end_accW got %b exp 1", accW); end
    read_block(32'h2080);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL gap_nbeats got %0d exp 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== 128'hB0 + 128'(i)) begin errors++; $display("FAIL gap_beat%0d_data got %h exp %h", i, rd_data[i], 128'hB0 + 128'(i)); end
    end
  endtask

  task automatic test_alias();
    for (int i = 0; i < 4; i++) write_beat(32'h0000_0040, 2'(i), 128'hC0 + 128'(i));
    read_block(32'h0001_0040);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL alias_nbeats got %0d exp 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== 128'hC0 + 128'(i)) begin errors++; $display("FAIL alias_beat%0d_data got %h exp %h", i, rd_data[i], 128'hC0 + 128'(i)); end
    end
  endtask

  task automatic test_flush();
    int pulses;
    int first_k;
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_idle_pulse got %b exp 1", flush_done); end
    @(negedge clk);
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_idle_single got %b exp 0", flush_done); end
    // Read busy: two flush_in pulses while pending, one acknowledge when back in IDLE.
    pulses = 0; first_k = 0;
    addrB = 32'h40; enB = 1'b1;
    @(negedge clk);
    enB = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (flush_done) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      flush_in = (k == 1 || k == 3);
    end
    flush_in = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL flush_busy_pulses got %0d exp 1", pulses); end
    checks++; if (first_k !== 7) begin errors++; $display("FAIL flush_busy_cycle got %0d exp 7", first_k); end
  endtask

  task automatic test_collide();
    int ready_seen;
    apply_reset();
    ready_seen = 0;
    addrB = 32'h3000; weB = 1'b1; enB = 1'b1; doutBstrobe = 2'd0; doutB = 128'hD0;
    @(negedge clk);
    weB = 1'b0; enB = 1'b0;
    if (dreadyB) ready_seen++;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL collide_proto_err got %b exp 1", proto_err); end
    checks++; if (accW !== 1'b0) begin errors++; $display("FAIL collide_accW got %b exp 0", accW); end
    for (int i = 1; i < 4; i++) begin
      write_beat(32'h3000, 2'(i), 128'hD0 + 128'(i));
      if (dreadyB) ready_seen++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dreadyB) ready_seen++;
    end
    checks++; if (ready_seen !== 0) begin errors++; $display("FAIL collide_dreadyB got %0d beats exp 0", ready_seen); end
    checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL collide_wr_count got %0d exp 1", wr_count); end
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL collide_rd_count got %0d exp 0", rd_count); end
  endtask

  task automatic test_reset_mid_read();
    int waited;
    waited = 0;
    addrB = 32'h1040; enB = 1'b1;
    @(negedge clk);
    enB = 1'b0;
    while (!dreadyB && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (dreadyB !== 1'b1) begin errors++; $display("FAIL midrd_beat_timeout got %b exp 1", dreadyB); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dreadyB !== 1'b0) begin errors++; $display("FAIL midrd_async_dreadyB got %b exp 0", dreadyB); end
    checks++; if (accR !== 1'b1) begin errors++; $display("FAIL midrd_async_accR got %b exp 1", accR); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_block(32'h1040);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL retain_nbeats got %0d exp 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== 128'hA0 + 128'(i)) begin errors++; $display("FAIL retain_beat%0d_data got %h exp %h", i, rd_data[i], 128'hA0 + 128'(i)); end
    end
    checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL retain_rd_count got %0d exp 1", rd_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_gap_stray();
    test_alias();
    test_flush();
    test_collide();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
